// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and frame geometry.
// Used by both the master and the slave ends of the link.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_state_t;

  localparam int unsigned SPI_FRAME_W = 40;
  localparam int unsigned SPI_CMD_W   = 8;
  localparam int unsigned SPI_DATA_W  = 32;

endpackage

// File: rtl/spi_clk_tick.sv
// SCK phase divider: one-cycle tick every CLK_DIV system clocks.
// The FSM clears it on every state change so each phase starts aligned.
module spi_clk_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  assign tick_o = (div_q == DIV_MAX);

  always_comb begin
    div_d = div_q + 1'b1;
    if (clr_i || tick_o) div_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) div_q <= '0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one FRAME_W-bit frame per start, MSB first,
// SCK derived from the system clock by spi_clk_tick.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_W = SPI_FRAME_W,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic [FRAME_W-1:0] iTx_Data,
  output logic               oBusy,
  output logic               oDone,
  output logic [FRAME_W-1:0] oRx_Data,
  output logic               oSPI_CLK,
  output logic               oSPI_CS,
  output logic               oSPI_MOSI,
  input  logic               iSPI_MISO
);

  localparam int unsigned CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W);

  spi_state_t         state_q, state_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [FRAME_W-1:0] rx_out_q, rx_out_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic               done_q, done_d;
  logic               tick;
  logic               state_change;

  assign state_change = (state_d != state_q);

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .clr_i  (state_change),
    .tick_o (tick)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      rx_out_q <= '0;
      bit_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rx_out_q <= rx_out_d;
      bit_q    <= bit_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rx_out_d = rx_out_q;
    bit_d    = bit_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = SETUP;
          tx_d    = iTx_Data;
          bit_d   = '0;
        end
      end
      SETUP: if (tick) state_d = HIGH;
      HIGH: begin
        if (tick) begin
          rx_d  = {rx_q[FRAME_W-2:0], iSPI_MISO};
          bit_d = bit_q + 1'b1;
          // TX shifts on the HIGH->LOW edge only, so HOLD keeps the last bit
          if (bit_d == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            state_d = LOW;
            tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      LOW: if (tick) state_d = HIGH;
      HOLD: begin
        if (tick) begin
          state_d  = GAP;
          rx_out_d = rx_q;
          done_d   = 1'b1;
        end
      end
      GAP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oSPI_CS   = 1'b1;
    oSPI_CLK  = 1'b0;
    oSPI_MOSI = 1'b0;
    oBusy     = (state_q != IDLE);
    if (state_q inside {SETUP, HIGH, LOW, HOLD}) begin
      oSPI_CS   = 1'b0;
      oSPI_MOSI = tx_q[FRAME_W-1];
    end
    if (state_q == HIGH) oSPI_CLK = 1'b1;
  end

  assign oDone    = done_q;
  assign oRx_Data = rx_out_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: loopback, constant and slave-model MISO,
// frame timing, ignored starts, mid-frame reset and back-to-back frames.
module tb_spi_master;

  localparam int unsigned FW = 40;

  logic          clk = 1'b0;
  logic          rst, start, miso;
  logic [FW-1:0] txd;
  logic          busy, done, sck, cs, mosi;
  logic [FW-1:0] rxd;

  spi_master #(.FRAME_W(FW), .CLK_DIV(4)) dut (
    .iCLK      (clk),
    .iRST      (rst),
    .iStart    (start),
    .iTx_Data  (txd),
    .oBusy     (busy),
    .oDone     (done),
    .oRx_Data  (rxd),
    .oSPI_CLK  (sck),
    .oSPI_CS   (cs),
    .oSPI_MOSI (mosi),
    .iSPI_MISO (miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] tx;
    logic [FW-1:0] rx;
  } exp_t;

  exp_t          q[$];
  int unsigned   n_tests = 0, n_fail = 0;
  int unsigned   done_cnt = 0, n_pushed = 0;
  logic [1:0]    mode = 2'd0;
  logic [FW-1:0] sl_pattern = '0, sl_sh = '0;

  // Bench-side slave: MSB out when CS falls, next bit after each SCK fall
  always @(negedge cs) sl_sh = sl_pattern;
  always @(negedge sck) if (!cs) begin #1 sl_sh = {sl_sh[FW-2:0], 1'b0}; end
  assign miso = (mode == 2'd0) ? mosi : (mode == 2'd1) ? 1'b1 : sl_sh[FW-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [FW-1:0] tx);
    exp_t e;
    e.tx = tx;
    e.rx = (mode == 2'd0) ? tx : (mode == 2'd1) ? '1 : sl_pattern;
    q.push_back(e);
    n_pushed++;
  endfunction

  // Monitor: sampled on the falling system clock edge
  logic          prev_cs = 1'b1, prev_sck = 1'b0;
  int unsigned   cs_len = 0, phase = 0, rises = 0, hi_run = 0, busy_run = 0;
  int            bitidx = 0;
  logic          busy_wait = 1'b0, b2b = 1'b0, seen = 1'b0;
  logic [FW-1:0] cur_tx = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_cs = 1'b1; prev_sck = 1'b0; busy_wait = 1'b0;
      cs_len = 0; phase = 0; hi_run = 0;
    end else begin
      if (busy_wait) begin
        busy_run++;
        if (!busy || busy_run > 10) begin
          check("busy_fall", busy_run, 4);
          busy_wait = 1'b0;
        end
      end
      if (prev_cs && !cs) begin
        cs_len = 1; phase = 1; rises = 0; bitidx = FW - 1;
        if (q.size() == 0) check("frame_unexp", 1'b1, q.size());
        else cur_tx = q[0].tx;
        if (b2b && seen) check("cs_gap", hi_run, 5);
        seen = b2b;
      end else if (!cs) begin
        cs_len++;
        if (sck != prev_sck) begin
          check("sck_half", phase, 4);
          phase = 1;
          if (sck) begin
            check("mosi_bit", mosi, cur_tx[bitidx]);
            rises++;
            bitidx--;
          end
        end else begin
          phase++;
        end
      end else if (!prev_cs && cs) begin
        check("cs_low_len", cs_len, 324);
        check("sck_rises", rises, FW);
        check("hold_len", phase, 4);
        check("mosi_idle", mosi, 1'b0);
        hi_run = 1;
      end else begin
        hi_run++;
      end
      if (done) begin
        check("done_cs", {prev_cs, cs}, 2'b01);
        if (q.size() == 0) begin
          check("done_unexp", 1'b1, q.size());
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rx_data", rxd, e.rx);
        end
        done_cnt++;
        busy_wait = 1'b1;
        busy_run  = 0;
      end
      prev_cs  = cs;
      prev_sck = sck;
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", busy, 1'b0);
  endtask

  task automatic send(input logic [FW-1:0] tx);
    wait_idle();
    @(posedge clk);
    #1 start = 1'b1; txd = tx; push(tx);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target);
    int unsigned n = 0;
    while (done_cnt < target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("done_wait", done_cnt, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] vals [3];
    int unsigned   n;
    vals[0] = 40'h11_22334455;
    vals[1] = 40'hC3_0F1E2D3C;
    vals[2] = 40'h80_00000001;
    rst = 1'b1; start = 1'b0; txd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cs", cs, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", rxd, '0);

    mode = 2'd0;
    send(40'hA5_DEADBEEF);
    wait_done(1);

    mode = 2'd1;
    send('0);
    wait_done(2);

    mode = 2'd2; sl_pattern = 40'h3C_12345678;
    send(40'h0F_0F0F0F0F);
    wait_done(3);

    mode = 2'd0;
    send(40'h01_23456789);
    repeat (100) @(posedge clk);
    #1 start = 1'b1; txd = 40'hFE_DCBA9876;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(4);
    repeat (400) @(posedge clk);
    check("ignored_start", done_cnt, 4);
    check("ignored_busy", busy, 1'b0);

    send(40'h5A_5A5A5A5A);
    rises = 0;
    n = 0;
    while (rises < 17 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("rst_bit17", rises, 17);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cs", cs, 1'b1);
    check("mid_rst_sck", sck, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_rx", rxd, '0);
    q.delete();
    n_pushed--;
    #10 rst = 1'b0;
    repeat (400) @(posedge clk);
    check("rst_no_done", done_cnt, 4);
    check("rst_rx_hold", rxd, '0);

    mode = 2'd0; b2b = 1'b1; seen = 1'b0;
    wait_idle();
    for (int k = 0; k < 3; k++) push(vals[k]);
    @(posedge clk);
    #1 txd = vals[0]; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(5 + k);
      #1;
      if (k < 2) txd = vals[k+1];
      else start = 1'b0;
    end
    repeat (50) @(posedge clk);
    b2b = 1'b0;
    check("frame_count", done_cnt, n_pushed);
    check("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
